// File: rtl/debounce_multi_if.sv
// Front-panel button bundle: raw levels in, debounced level and strobes out.
// The master side (panel/bench) drives the raw buttons, the slave side
// (the conditioner) drives everything else.
interface debounce_multi_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] button;     // raw asynchronous levels, 1 = pressed
    logic [WIDTH-1:0] debounced;  // conditioned level per channel
    logic [WIDTH-1:0] rise;       // one clock on debounced 0->1
    logic [WIDTH-1:0] fall;       // one clock on debounced 1->0
    logic [WIDTH-1:0] press;      // rise plus every auto-repeat event

    modport master (
        output button,
        input  debounced,
        input  rise,
        input  fall,
        input  press
    );

    modport slave (
        input  button,
        output debounced,
        output rise,
        output fall,
        output press
    );
endinterface

// File: rtl/debounce_multi.sv
// N-channel push-button conditioner: two-flop synchroniser, stable-time
// debounce, single-cycle rise/fall strobes and an optional auto-repeat press
// strobe for held buttons. Channels are fully independent.
module debounce_multi #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 250000,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 50000,
    parameter int CNT_W         = 18
) (
    input logic             clk,
    input logic             reset,
    debounce_multi_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    // Terminal counts; a counter reaching its *_LAST value fires on that edge.
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam bit               REPEAT_EN   = (REPEAT_DELAY != 0);

    // Synchroniser stages; only sync0 is used downstream.
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync0;

    // Debounce state and registered strobes.
    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] press_q;

    // Per-channel counters and repeat state.
    logic [CNT_W-1:0] stable_cnt [WIDTH];
    logic [CNT_W-1:0] hold_cnt   [WIDTH];
    rpt_state_t       rpt_state  [WIDTH];

    // Decisions taken on the current edge.
    logic [WIDTH-1:0] flip;        // debounced level changes this edge
    logic [WIDTH-1:0] flip_up;     // ... and becomes 1
    logic [WIDTH-1:0] flip_down;   // ... and becomes 0
    logic [WIDTH-1:0] repeat_hit;  // auto-repeat strobe due next clock

    // Bring the raw asynchronous levels into the clock domain.
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours, which is what makes
    // sync1 -> sync0 a real two-stage shift rather than a single wire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync0 <= '0;
        end else begin
            sync1 <= bus.button;
            sync0 <= sync1;
        end
    end

    // Work out which channels toggle and which owe a repeat strobe this edge.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a bit unassigned and infer a latch.
    always_comb begin
        flip       = '0;
        flip_up    = '0;
        flip_down  = '0;
        repeat_hit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            flip[i]      = (sync0[i] != deb_q[i]) && (stable_cnt[i] == STABLE_LAST);
            flip_up[i]   = flip[i] & ~deb_q[i];
            flip_down[i] = flip[i] &  deb_q[i];
            case (rpt_state[i])
                ST_DELAY:  repeat_hit[i] = (hold_cnt[i] == DELAY_LAST);
                ST_REPEAT: repeat_hit[i] = (hold_cnt[i] == PERIOD_LAST);
                default:   repeat_hit[i] = 1'b0;
            endcase
            // A release always wins over a repeat falling due on the same edge.
            repeat_hit[i] = repeat_hit[i] && REPEAT_EN && !flip_down[i];
        end
    end

    // Stable-time counter: counts consecutive disagreeing clocks, clears on
    // agreement or when the debounced level flips, so it never wraps.
    // NOTE: the counter arrays are real control state, not storage, so they
    // are cleared on reset like any other flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                stable_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync0[i] == deb_q[i] || flip[i]) begin
                    stable_cnt[i] <= '0;
                end else begin
                    stable_cnt[i] <= stable_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounced level and its edge strobes, all landing on the same clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            deb_q  <= deb_q ^ flip;
            rise_q <= flip_up;
            fall_q <= flip_down;
        end
    end

    // Auto-repeat FSM with its hold counter and the registered press strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                rpt_state[i] <= ST_IDLE;
                hold_cnt[i]  <= '0;
            end
        end else begin
            press_q <= flip_up | repeat_hit;
            for (int i = 0; i < WIDTH; i++) begin
                if (!REPEAT_EN || flip_down[i]) begin
                    rpt_state[i] <= ST_IDLE;
                    hold_cnt[i]  <= '0;
                end else begin
                    case (rpt_state[i])
                        ST_IDLE: begin
                            hold_cnt[i] <= '0;
                            if (flip_up[i]) begin
                                rpt_state[i] <= ST_DELAY;
                            end
                        end
                        ST_DELAY: begin
                            if (repeat_hit[i]) begin
                                rpt_state[i] <= ST_REPEAT;
                                hold_cnt[i]  <= '0;
                            end else begin
                                hold_cnt[i] <= hold_cnt[i] + CNT_W'(1);
                            end
                        end
                        ST_REPEAT: begin
                            if (repeat_hit[i]) begin
                                hold_cnt[i] <= '0;
                            end else begin
                                hold_cnt[i] <= hold_cnt[i] + CNT_W'(1);
                            end
                        end
                        default: begin
                            rpt_state[i] <= ST_IDLE;
                            hold_cnt[i]  <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.debounced = deb_q;
    assign bus.rise      = rise_q;
    assign bus.fall      = fall_q;
    assign bus.press     = press_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model. Two instances share the stimulus,
// one with auto-repeat enabled and one with it disabled.
module tb_debounce_multi;

    localparam int W = 4;
    localparam int S = 4;   // STABLE_CYCLES
    localparam int D = 10;  // REPEAT_DELAY
    localparam int P = 3;   // REPEAT_PERIOD

    logic clk;
    logic reset;

    debounce_multi_if #(.WIDTH(W)) bus_rep ();
    debounce_multi_if #(.WIDTH(W)) bus_norep ();

    debounce_multi #(
        .WIDTH(W), .STABLE_CYCLES(S), .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .CNT_W(8)
    ) dut_rep (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_rep)
    );

    debounce_multi #(
        .WIDTH(W), .STABLE_CYCLES(S), .REPEAT_DELAY(0), .REPEAT_PERIOD(P), .CNT_W(8)
    ) dut_norep (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_norep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: two-clock delay line, disagreement run length,
    // debounced level and clocks elapsed since the last rise.
    logic   m_d1 [W];
    logic   m_d2 [W];
    int     m_run [W];
    logic   m_deb [W];
    int     m_since [W];
    logic [W-1:0] e_deb, e_rise, e_fall, e_press_rep, e_press_norep;

    task automatic set_buttons(input logic [W-1:0] b);
        bus_rep.button   = b;
        bus_norep.button = b;
    endtask

    task automatic model_clear();
        for (int i = 0; i < W; i++) begin
            m_d1[i] = 1'b0; m_d2[i] = 1'b0; m_run[i] = 0;
            m_deb[i] = 1'b0; m_since[i] = -1;
        end
        e_deb = '0; e_rise = '0; e_fall = '0; e_press_rep = '0; e_press_norep = '0;
    endtask

    // Advance the model by one rising edge using the button levels present at it.
    task automatic model_step();
        logic flipped;
        if (!reset) begin
            model_clear();
            return;
        end
        for (int i = 0; i < W; i++) begin
            flipped = 1'b0;
            if (m_d2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == S) begin
                    flipped  = 1'b1;
                    m_run[i] = 0;
                    m_deb[i] = ~m_deb[i];
                end
            end else begin
                m_run[i] = 0;
            end
            e_deb[i]  = m_deb[i];
            e_rise[i] = flipped && m_deb[i];
            e_fall[i] = flipped && !m_deb[i];
            if (e_rise[i])     m_since[i] = 0;
            else if (m_deb[i]) m_since[i]++;
            else               m_since[i] = -1;
            e_press_rep[i] = m_deb[i] && (m_since[i] == 0 ||
                             (m_since[i] >= D && ((m_since[i] - D) % P) == 0));
            e_press_norep[i] = e_rise[i];
            m_d2[i] = m_d1[i];
            m_d1[i] = bus_rep.button[i];
        end
    endtask

    // One clock: the model follows the edge, outputs are then sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({bus_rep.debounced, bus_rep.rise, bus_rep.fall, bus_rep.press} !== 16'h0) begin
            bad++;
            $display("FAIL reset_rep: got %h expected 0000",
                     {bus_rep.debounced, bus_rep.rise, bus_rep.fall, bus_rep.press});
        end
        set_buttons(4'b1111);
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({bus_norep.debounced, bus_norep.rise, bus_norep.fall, bus_norep.press} !== 16'h0) begin
                bad++;
                $display("FAIL reset_hold_norep: got %h expected 0000",
                         {bus_norep.debounced, bus_norep.rise, bus_norep.fall, bus_norep.press});
            end
        end
        set_buttons(4'b0000);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_clean_press();
        logic [W-1:0] x_deb, x_rise, x_fall;
        set_buttons(4'b0001);
        for (int k = 1; k <= 20; k++) begin
            if (k == 9) set_buttons(4'b0000);
            tick();
            x_deb  = (k >= 6 && k < 14) ? 4'b0001 : 4'b0000;
            x_rise = (k == 6)  ? 4'b0001 : 4'b0000;
            x_fall = (k == 14) ? 4'b0001 : 4'b0000;
            total++;
            if (bus_rep.debounced !== x_deb) begin
                bad++; $display("FAIL clean_deb k=%0d: got %b expected %b", k, bus_rep.debounced, x_deb);
            end
            total++;
            if (bus_rep.rise !== x_rise) begin
                bad++; $display("FAIL clean_rise k=%0d: got %b expected %b", k, bus_rep.rise, x_rise);
            end
            total++;
            if (bus_rep.fall !== x_fall) begin
                bad++; $display("FAIL clean_fall k=%0d: got %b expected %b", k, bus_rep.fall, x_fall);
            end
            total++;
            if (bus_rep.press !== x_rise) begin
                bad++; $display("FAIL clean_press k=%0d: got %b expected %b", k, bus_rep.press, x_rise);
            end
            total++;
            if (bus_norep.press !== x_rise) begin
                bad++; $display("FAIL clean_press_norep k=%0d: got %b expected %b", k, bus_norep.press, x_rise);
            end
        end
    endtask

    task automatic test_bounce();
        logic v;
        int   rises = 0;
        for (int j = 1; j <= 40; j++) begin
            v = (j <= 20) ? (((j - 1) % 4) < 3) : 1'b1;
            set_buttons({2'b00, v, 1'b0});
            tick();
            if (bus_rep.rise[1]) rises++;
            total++;
            if (bus_rep.rise[1] !== (j == 26)) begin
                bad++; $display("FAIL bounce_rise j=%0d: got %b expected %b", j, bus_rep.rise[1], (j == 26));
            end
            total++;
            if (bus_rep.debounced[1] !== (j >= 26)) begin
                bad++; $display("FAIL bounce_deb j=%0d: got %b expected %b", j, bus_rep.debounced[1], (j >= 26));
            end
        end
        set_buttons(4'b0000);
        for (int j = 0; j < 12; j++) begin
            tick();
            if (bus_rep.rise[1]) rises++;
        end
        total++;
        if (rises !== 1) begin
            bad++; $display("FAIL bounce_rise_count: got %0d expected 1", rises);
        end
        total++;
        if (bus_rep.debounced !== 4'b0000) begin
            bad++; $display("FAIL bounce_released: got %b expected 0000", bus_rep.debounced);
        end
    endtask

    task automatic test_auto_repeat();
        logic [W-1:0] x_press, x_fall, x_deb;
        for (int k = 1; k <= 45; k++) begin
            set_buttons((k < 32) ? 4'b0100 : 4'b0000);
            tick();
            x_press = (k == 6 || k == 16 || k == 19 || k == 22 || k == 25 ||
                       k == 28 || k == 31 || k == 34) ? 4'b0100 : 4'b0000;
            x_fall  = (k == 37) ? 4'b0100 : 4'b0000;
            x_deb   = (k >= 6 && k < 37) ? 4'b0100 : 4'b0000;
            total++;
            if (bus_rep.press !== x_press) begin
                bad++; $display("FAIL repeat_press k=%0d: got %b expected %b", k, bus_rep.press, x_press);
            end
            total++;
            if (bus_rep.fall !== x_fall) begin
                bad++; $display("FAIL repeat_fall k=%0d: got %b expected %b", k, bus_rep.fall, x_fall);
            end
            total++;
            if (bus_rep.debounced !== x_deb) begin
                bad++; $display("FAIL repeat_deb k=%0d: got %b expected %b", k, bus_rep.debounced, x_deb);
            end
            total++;
            if (bus_norep.press !== ((k == 6) ? 4'b0100 : 4'b0000)) begin
                bad++; $display("FAIL norepeat_press k=%0d: got %b expected %b", k, bus_norep.press,
                                ((k == 6) ? 4'b0100 : 4'b0000));
            end
        end
    endtask

    task automatic test_reset_mid();
        set_buttons(4'b1000);
        for (int k = 1; k <= 10; k++) begin
            tick();
            total++;
            if (bus_rep.rise !== ((k == 6) ? 4'b1000 : 4'b0000)) begin
                bad++; $display("FAIL midrst_pre_rise k=%0d: got %b", k, bus_rep.rise);
            end
        end
        reset = 1'b0;
        model_clear();
        #1;
        total++;
        if ({bus_rep.debounced, bus_rep.rise, bus_rep.fall, bus_rep.press} !== 16'h0) begin
            bad++; $display("FAIL midrst_async: got %h expected 0000",
                            {bus_rep.debounced, bus_rep.rise, bus_rep.fall, bus_rep.press});
        end
        tick();
        tick();
        reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            total++;
            if (bus_rep.debounced !== ((k >= 6) ? 4'b1000 : 4'b0000)) begin
                bad++; $display("FAIL midrst_deb k=%0d: got %b", k, bus_rep.debounced);
            end
            total++;
            if (bus_rep.rise !== ((k == 6) ? 4'b1000 : 4'b0000)) begin
                bad++; $display("FAIL midrst_rise k=%0d: got %b", k, bus_rep.rise);
            end
            total++;
            if (bus_rep.press !== ((k == 6) ? 4'b1000 : 4'b0000)) begin
                bad++; $display("FAIL midrst_press k=%0d: got %b", k, bus_rep.press);
            end
        end
        set_buttons(4'b0000);
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_simultaneous();
        for (int k = 1; k <= 20; k++) begin
            set_buttons((k <= 8) ? 4'b1111 : 4'b0000);
            tick();
            total++;
            if (bus_rep.rise !== ((k == 6) ? 4'b1111 : 4'b0000)) begin
                bad++; $display("FAIL simul_rise k=%0d: got %b", k, bus_rep.rise);
            end
            total++;
            if (bus_rep.fall !== ((k == 14) ? 4'b1111 : 4'b0000)) begin
                bad++; $display("FAIL simul_fall k=%0d: got %b", k, bus_rep.fall);
            end
            total++;
            if (bus_rep.press !== ((k == 6) ? 4'b1111 : 4'b0000)) begin
                bad++; $display("FAIL simul_press k=%0d: got %b", k, bus_rep.press);
            end
            total++;
            if (bus_norep.debounced !== ((k >= 6 && k < 14) ? 4'b1111 : 4'b0000)) begin
                bad++; $display("FAIL simul_deb k=%0d: got %b", k, bus_norep.debounced);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] lvl = '0;
        int rem [W];
        for (int i = 0; i < W; i++) rem[i] = 0;
        for (int n = 0; n < 700; n++) begin
            if (n == 350) begin
                reset = 1'b0;
                model_clear();
                #1;
                total++;
                if ({bus_rep.debounced, bus_rep.rise, bus_rep.fall, bus_rep.press} !== 16'h0) begin
                    bad++; $display("FAIL rand_reset: got %h expected 0000",
                                    {bus_rep.debounced, bus_rep.rise, bus_rep.fall, bus_rep.press});
                end
                tick();
                reset = 1'b1;
            end
            for (int i = 0; i < W; i++) begin
                if (rem[i] == 0) begin
                    lvl[i] = 1'($urandom_range(0, 1));
                    rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 40))
                                                         : int'($urandom_range(1, 7));
                end
                rem[i]--;
            end
            set_buttons(lvl);
            tick();
            total++;
            if (bus_rep.debounced !== e_deb) begin
                bad++; $display("FAIL rand_deb n=%0d: got %b expected %b", n, bus_rep.debounced, e_deb);
            end
            total++;
            if (bus_rep.rise !== e_rise) begin
                bad++; $display("FAIL rand_rise n=%0d: got %b expected %b", n, bus_rep.rise, e_rise);
            end
            total++;
            if (bus_rep.fall !== e_fall) begin
                bad++; $display("FAIL rand_fall n=%0d: got %b expected %b", n, bus_rep.fall, e_fall);
            end
            total++;
            if (bus_rep.press !== e_press_rep) begin
                bad++; $display("FAIL rand_press n=%0d: got %b expected %b", n, bus_rep.press, e_press_rep);
            end
            total++;
            if (bus_norep.press !== e_press_norep) begin
                bad++; $display("FAIL rand_press_norep n=%0d: got %b expected %b", n, bus_norep.press,
                                e_press_norep);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        set_buttons(4'b0000);
        model_clear();
        #12;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised N-channel push-button conditioner for the vending machine front panel. Replaces the per-bit debounce instances with one block. Each channel gets:
- a two-flop synchroniser
- a stable-time counter with a programmable interval
- single-cycle press/release strobes
- an optional auto-repeat press strobe for held buttons (coin-select and quantity keys).

All channels are independent and share one clock and reset.

## Interface
- WIDTH, 4, number of button channels (1..32)
- STABLE_CYCLES, 250000, synchronised input must differ from the debounced state this many consecutive clocks before the state flips (>= 2)
- REPEAT_DELAY, 0, hold clocks after a press before the first repeat strobe; 0 disables auto-repeat
- REPEAT_PERIOD, 50000, clocks between subsequent repeat strobes (>= 1; ignored when REPEAT_DELAY = 0)
- CNT_W, 18, counter width; must satisfy 2^CNT_W > max(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- button  input  WIDTH  raw, asynchronous button levels (1 = pressed)
- debounced  output  WIDTH  registered, debounced level per channel
- rise  output  WIDTH  one-clock strobe on a debounced 0->1 transition
- fall  output  WIDTH  one-clock strobe on a debounced 1->0 transition
- press  output  WIDTH  one-clock strobe on rise plus each auto-repeat event

## Operation
- reset low: sync flops, counters, debounced, rise, fall and press all clear to 0 immediately.
- Per channel, the sync stage is s1 <= button[i] and s0 <= s1; s0 is the only signal used downstream.
- Stable counter:
  - s0 == debounced[i]: counter <= 0.
  - s0 != debounced[i] and counter < STABLE_CYCLES-1: counter increments.
  - s0 != debounced[i] and counter == STABLE_CYCLES-1: debounced[i] toggles and counter <= 0.
- A glitch shorter than STABLE_CYCLES clocks at s0 clears the counter and causes no output change.
- rise[i]/fall[i] are registered and high for exactly the one clock in which debounced[i] first shows its new value.
- press[i] is high whenever rise[i] is high.
- Repeat FSM per channel:
  - States: IDLE, DELAY, REPEAT.
  - IDLE -> DELAY on the toggle to 1 when REPEAT_DELAY != 0; the hold counter clears.
  - DELAY: hold counter counts. At REPEAT_DELAY-1, press[i] strobes next clock, state -> REPEAT and the counter clears.
  - REPEAT: at REPEAT_PERIOD-1, press[i] strobes next clock and the counter clears.
  - Any state -> IDLE with the counter cleared when debounced[i] falls, or always when REPEAT_DELAY == 0.
- A release ends repeat immediately. No press strobe is issued in the clock where fall[i] is high.
- Stable and hold counters are separate per channel; both saturate logically by clearing and never wrap.
- The block has no cross-channel interaction. Simultaneous events on different channels produce simultaneous strobes.

## Timing
- Press latency: a raw edge held steady reaches s0 after 2 clocks, and debounced flips STABLE_CYCLES clocks later. Total is 2 + STABLE_CYCLES clocks ±1 for input sampling phase.
- Release latency is identical.
- rise, fall and press are coincident with the first cycle of the new debounced level.
- First repeat strobe comes REPEAT_DELAY clocks after the rise strobe; later strobes are REPEAT_PERIOD clocks apart.
- Minimum debounced pulse width is STABLE_CYCLES clocks.
- Reset asserted mid-count or mid-repeat discards all state.
- Release of reset with a button already held: the channel behaves as a fresh press after 2 + STABLE_CYCLES clocks, including rise and press.

## Test plan
- Bench parameters for all scenarios: WIDTH=4, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: button[0] 0->1 held -> debounced[0]=1 after 6 clocks; rise[0] and press[0] high one clock; other channels stay 0.
- Bounce rejection: button[1] toggles high for 3 clocks, low for 1, repeated 5 times, then high steady -> no rise until 4 stable s0 clocks after the last toggle; exactly one rise[1].
- Auto-repeat: hold button[2] for 30 clocks after rise -> press[2] strobes at +0, +10, +13, +16, +19, +22, +25, +28. Release -> fall[2] after 6 clocks; no press strobe after release.
- Repeat disabled: rerun with REPEAT_DELAY=0 and a 30-clock hold -> exactly one press strobe, equal to rise.
- Reset mid-operation: assert reset during the DELAY state with button[3] held -> all outputs 0 immediately. Release reset -> debounced[3]=1 and rise[3] 6 clocks later.
- Simultaneous channels: button = 4'b1111 for 8 clocks, then 4'b0000 -> rise = 4'b1111 on one clock, later fall = 4'b1111 on one clock.
